// File: rtl/sha_pkg.sv
// sha_pkg: shared types and helpers for the SHA-256 job sequencer.
//   HashState   - 8x32 chaining/digest state, word a in [255:224]
//   SHA256_IV   - initial hash value
//   s0 / s1     - message-schedule small sigmas
//   hs_add      - word-wise feed-forward add (no carry between words)
package sha_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } HashState;

   localparam HashState SHA256_IV = HashState'(
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   function automatic HashState hs_add(input HashState x, input HashState y);
      HashState r;
      r.a = x.a + y.a;
      r.b = x.b + y.b;
      r.c = x.c + y.c;
      r.d = x.d + y.d;
      r.e = x.e + y.e;
      r.f = x.f + y.f;
      r.g = x.g + y.g;
      r.h = x.h + y.h;
      return r;
   endfunction

endpackage

// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule: 16-word sliding window producing W_t one word per advance.
//   clk, rst    - clock, async active-high reset
//   load_i      - load window with the 16 block words (priority over advance)
//   advance_i   - shift window by one word, appending the next expanded word
//   block_i     - 512-bit message block, word 0 in [511:480]
//   w_o         - current schedule word (window head)
module sha_msg_schedule
   import sha_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         advance_i,
   input  logic [511:0] block_i,
   output logic [31:0]  w_o
);

   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] w_next;

   // With W_t at the head, this is W_{t+16}.
   assign w_next = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];

   always_comb begin
      win_d = win_q;
      if (load_i) begin
         for (int i = 0; i < 16; i++) begin
            win_d[i] = block_i[511 - 32*i -: 32];
         end
      end else if (advance_i) begin
         for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
         end
         win_d[15] = w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         win_q <= win_d;
      end
   end

   assign w_o = win_q[0];

endmodule

// File: rtl/sha_job_sequencer.sv
// sha_job_sequencer: runs an external sha_compressor as a one-block job engine.
//   job_*               - job handshake: chaining state + 512-bit block
//   res_*               - result FIFO head: feed-forwarded digest
//   cmp_counter/W/...   - drive the compressor; cmp_hash is its state output
//   busy                - a compression is in flight
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | counter parked at 0, waiting for a job
// ST_RUN  | counter 1..63 computing; counter==0 in RUN is the FINISH cycle,
//         | which pushes the digest and may accept the next job
module sha_job_sequencer
   import sha_pkg::*;
#(
   parameter int RES_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_hash,
   input  logic [511:0] job_block,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [255:0] res_hash,
   output logic [5:0]   cmp_counter,
   output logic [31:0]  cmp_W,
   output logic [255:0] cmp_inputhashstate,
   input  logic [255:0] cmp_hash,
   output logic         busy
);

   localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int CNT_W = $clog2(RES_DEPTH + 1);

   seq_state_t       state_q, state_d;
   logic [5:0]       counter_q, counter_d;
   HashState         saved_h_q, saved_h_d;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W:0]   occ_after;
   HashState         fifo_mem_q [RES_DEPTH];

   logic             finishing;
   logic             start_point;
   logic             accept;
   logic             pop;
   logic             push;
   HashState         push_hash;
   logic [31:0]      sched_w;

   assign finishing   = (state_q == ST_RUN) && (counter_q == 6'd0);
   assign start_point = (state_q == ST_IDLE) || finishing;
   assign pop         = res_valid && res_ready;
   assign push        = finishing;
   assign push_hash   = hs_add(HashState'(cmp_hash), saved_h_q);

   // Admit a job only if its completion is guaranteed a free FIFO slot:
   // occupancy after this edge must leave room for one more result.
   assign occ_after = (CNT_W+1)'(count_q) + (CNT_W+1)'(finishing) - (CNT_W+1)'(pop);
   assign job_ready = start_point && (occ_after <= (CNT_W+1)'(1));
   assign accept    = job_valid && job_ready;

   sha_msg_schedule u_sched (
      .clk       (clk),
      .rst       (rst),
      .load_i    (accept),
      .advance_i (state_q == ST_RUN),
      .block_i   (job_block),
      .w_o       (sched_w)
   );

   always_comb begin
      state_d   = state_q;
      counter_d = '0;
      saved_h_d = saved_h_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_RUN;
               counter_d = 6'd1;
               saved_h_d = HashState'(job_hash);
            end
         end
         ST_RUN: begin
            if (counter_q != 6'd0) begin
               // 63 + 1 wraps to 0, landing on the FINISH cycle.
               counter_d = counter_q + 6'd1;
            end else if (accept) begin
               counter_d = 6'd1;
               saved_h_d = HashState'(job_hash);
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
         saved_h_q <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         saved_h_q <= saved_h_d;
      end
   end

   assign busy               = (state_q == ST_RUN);
   assign cmp_counter        = counter_q;
   assign cmp_W              = busy ? sched_w : 32'd0;
   assign cmp_inputhashstate = start_point ? job_hash : saved_h_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= push_hash;
      end
   end

   assign res_valid = (count_q != '0);
   assign res_hash  = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sha_job_sequencer.sv
module tb_sha_job_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         job_valid;
   logic         job_ready;
   logic [255:0] job_hash;
   logic [511:0] job_block;
   logic         res_valid;
   logic         res_ready;
   logic [255:0] res_hash;
   logic [5:0]   cmp_counter;
   logic [31:0]  cmp_W;
   logic [255:0] cmp_inputhashstate;
   logic [255:0] cmp_hash;
   logic         busy;

   always #5 clk = ~clk;

   sha_job_sequencer dut (
      .clk                (clk),
      .rst                (rst),
      .job_valid          (job_valid),
      .job_ready          (job_ready),
      .job_hash           (job_hash),
      .job_block          (job_block),
      .res_valid          (res_valid),
      .res_ready          (res_ready),
      .res_hash           (res_hash),
      .cmp_counter        (cmp_counter),
      .cmp_W              (cmp_W),
      .cmp_inputhashstate (cmp_inputhashstate),
      .cmp_hash           (cmp_hash),
      .busy               (busy)
   );

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] TB_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 32'h00000018, 32'h0};
   localparam logic [511:0] ABC_PAD = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] TWO_B1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
      32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] TWO_DIGEST =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   // ---------------- reference SHA-256 (plain algorithm) ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k,
                                         input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [31:0] sched_word(input logic [511:0] blk, input int t);
      logic [31:0] w [64];
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = blk[511 - 32*i -: 32];
         else        w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
      end
      return w[t];
   endfunction

   function automatic logic [255:0] sha_ref(input logic [255:0] h0, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [255:0] s;
      logic [255:0] r;
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = blk[511 - 32*i -: 32];
         else        w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
      end
      s = h0;
      for (int i = 0; i < 64; i++) s = rnd(s, K[i], w[i]);
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = s[255 - 32*i -: 32] + h0[255 - 32*i -: 32];
      return r;
   endfunction

   // ---------------- compressor stand-in ----------------
   // Loads inputhashstate while counter==0; round (counter-1) mod 64 uses the
   // current W, and its result is visible combinationally on cmp_hash.
   logic [255:0] cst;
   logic [5:0]   kidx;
   assign kidx     = cmp_counter - 6'd1;
   assign cmp_hash = rnd(cst, K[kidx], cmp_W);
   always @(posedge clk) begin
      if (cmp_counter == 6'd0) cst <= cmp_inputhashstate;
      else                     cst <= rnd(cst, K[kidx], cmp_W);
   end

   // ---------------- bookkeeping ----------------
   int           cyc = 0;
   int           errs = 0;
   int           checks = 0;
   logic [255:0] exp_q [$];
   int           pop_cyc_q [$];
   logic [255:0] last_res;
   bit           rnd_on = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errs++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard monitor: every result the consumer takes is checked in order.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_result: got %h expected none", res_hash);
         end else begin
            chk("result", res_hash, exp_q.pop_front());
         end
         last_res = res_hash;
         pop_cyc_q.push_back(cyc);
      end
   end

   // Called just after a rising edge; returns after the accepting edge.
   task automatic send_job(input logic [255:0] h, input logic [511:0] b,
                           input int budget, output int acc);
      job_hash  = h;
      job_block = b;
      job_valid = 1'b1;
      acc       = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (job_ready) begin
            acc = cyc;
            exp_q.push_back(sha_ref(h, b));
            break;
         end
      end
      @(posedge clk);
      #1;
      job_valid = 1'b0;
      if (acc < 0) fail_now("accept_timeout");
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) fail_now("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   function automatic logic [255:0] rand_h();
      logic [255:0] h;
      for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
      return h;
   endfunction

   logic [5:0]   tr_ctr [66];
   logic [31:0]  tr_w   [66];
   logic         tr_busy[66];
   logic         tr_rv  [66];
   logic [255:0] tr_rh  [66];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a1, a2, a3, rel, viol_ready, viol_hold, n;
      logic [255:0] held, mid;

      rst       = 1'b1;
      job_valid = 1'b0;
      job_hash  = rand_h();
      job_block = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk_int("rst_counter", int'(cmp_counter), 0);
      chk_int("rst_res_valid", int'(res_valid), 0);
      chk_int("rst_busy", int'(busy), 0);
      chk_int("rst_job_ready", int'(job_ready), 1);
      chk("rst_cmp_W", 256'(cmp_W), 256'd0);
      chk("idle_inputhash", cmp_inputhashstate, job_hash);
      @(posedge clk);
      #1;

      // "abc": counter/W trace, latency, digest
      res_ready = 1'b1;
      fork
         send_job(TB_IV, ABC_PAD, 10, a1);
         begin
            n = 0;
            @(negedge clk);
            while (!(job_valid && job_ready) && n < 10) begin
               @(negedge clk);
               n++;
            end
            for (int k = 0; k < 66; k++) begin
               tr_ctr[k]  = cmp_counter;
               tr_w[k]    = cmp_W;
               tr_busy[k] = busy;
               tr_rv[k]   = res_valid;
               tr_rh[k]   = res_hash;
               if (k < 65) @(negedge clk);
            end
         end
      join
      for (int k = 0; k < 65; k++) chk_int($sformatf("ctr_seq_%0d", k), int'(tr_ctr[k]), k % 64);
      chk("w_idle", 256'(tr_w[0]), 256'd0);
      chk("w_ctr1", 256'(tr_w[1]), 256'h61626380);
      chk("w_ctr16", 256'(tr_w[16]), 256'h18);
      for (int k = 1; k < 65; k++) chk($sformatf("w_trace_%0d", k), 256'(tr_w[k]), 256'(sched_word(ABC_PAD, k - 1)));
      chk_int("busy_at_accept", int'(tr_busy[0]), 0);
      chk_int("busy_in_finish", int'(tr_busy[64]), 1);
      chk_int("res_valid_T64", int'(tr_rv[64]), 0);
      chk_int("res_valid_T65", int'(tr_rv[65]), 1);
      chk("abc_digest", tr_rh[65], ABC_DIGEST);
      wait_idle(100);

      // two-block message chained through the reference digest of block 1
      mid = sha_ref(TB_IV, TWO_B1);
      send_job(TB_IV, TWO_B1, 10, a1);
      wait_idle(200);
      send_job(mid, TWO_B2, 10, a2);
      wait_idle(200);
      chk("two_block_digest", last_res, TWO_DIGEST);

      // three jobs with consumer stalled, then released
      res_ready = 1'b0;
      send_job(rand_h(), rand_blk(), 10, a1);
      send_job(rand_h(), rand_blk(), 80, a2);
      chk_int("job2_in_finish", a2 - a1, 64);
      rel = -1;
      fork
         send_job(rand_h(), rand_blk(), 200, a3);
         begin
            viol_ready = 0;
            viol_hold  = 0;
            @(negedge clk);
            held = res_hash;
            chk("held_head", held, exp_q[0]);
            for (int k = 0; k < 70; k++) begin
               if (job_ready) viol_ready++;
               if (!res_valid || res_hash !== held) viol_hold++;
               @(negedge clk);
            end
            chk_int("stall_job_ready_low", viol_ready, 0);
            chk_int("stall_head_stable", viol_hold, 0);
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            rel = cyc;
         end
      join
      chk_int("job3_accept_on_release", a3, rel);
      wait_idle(300);

      // back-to-back throughput
      pop_cyc_q.delete();
      send_job(rand_h(), rand_blk(), 10, a1);
      send_job(rand_h(), rand_blk(), 80, a2);
      chk_int("b2b_spacing", a2 - a1, 64);
      wait_idle(300);
      chk_int("b2b_pops", pop_cyc_q.size(), 2);
      if (pop_cyc_q.size() == 2) begin
         chk_int("b2b_lat1", pop_cyc_q[0] - a1, 65);
         chk_int("b2b_lat2", pop_cyc_q[1] - a2, 65);
      end

      // reset mid-computation with one result queued
      res_ready = 1'b0;
      send_job(rand_h(), rand_blk(), 10, a1);
      send_job(rand_h(), rand_blk(), 80, a2);
      n = 0;
      @(negedge clk);
      while (cmp_counter != 6'd30 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("wait_counter30");
      chk_int("pre_rst_res_valid", int'(res_valid), 1);
      #1 rst = 1'b1;
      #1;
      chk_int("rst_mid_counter", int'(cmp_counter), 0);
      chk_int("rst_mid_busy", int'(busy), 0);
      chk_int("rst_mid_res_valid", int'(res_valid), 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_int("post_rst_res_valid", int'(res_valid), 0);
      chk_int("post_rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      send_job(TB_IV, ABC_PAD, 10, a1);
      wait_idle(200);
      chk("post_rst_abc", last_res, ABC_DIGEST);

      // randomized jobs and consumer back-pressure
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk);
            #1;
            if (rnd_on) res_ready = 1'($urandom_range(0, 1));
         end
         begin
            for (int j = 0; j < 20; j++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               send_job(rand_h(), rand_blk(), 400, a1);
            end
            rnd_on = 1'b0;
         end
      join
      @(posedge clk);
      #1 res_ready = 1'b1;
      wait_idle(600);
      chk_int("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/sha_job_sequencer.md
Name: sha_job_sequencer

Overview:
Drives one sha_compressor instance as a job engine. It accepts a job (512-bit block plus 256-bit chaining state), generates the compressor's 6-bit counter and the per-round W words by expanding the message schedule, adds the chaining state back in (feed-forward), and queues finished digests in a 2-entry result FIFO. It sits between the block-assembly front end and the nonce/digest checking logic, and guarantees the compressor is never stalled mid-computation.

Parameters:
RES_DEPTH, 2, result FIFO entries; the job admission credit rule below is fixed for a depth of 2.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
job_valid  in  1  job offered
job_ready  out  1  job accepted when job_valid && job_ready at a rising edge
job_hash  in  256  chaining state (HashState, word a in [255:224])
job_block  in  512  message block, word 0 in [511:480]
res_valid  out  1  digest available at FIFO head
res_ready  in  1  consumer pops when res_valid && res_ready
res_hash  out  256  feed-forwarded digest (HashState)
cmp_counter  out  6  to compressor counter
cmp_W  out  32  to compressor W
cmp_inputhashstate  out  256  to compressor inputhashstate
cmp_hash  in  256  from compressor hash
busy  out  1  computation in flight

Behaviour:
- States: IDLE, RUN. Reset value: IDLE, cmp_counter=0, FIFO empty, res_valid=0, busy=0, cmp_W=0, job_ready=1.
- IDLE: cmp_counter held at 0. cmp_inputhashstate=job_hash (combinational). cmp_W=0.
- Start point = IDLE, or RUN with cmp_counter==0 (the FINISH cycle).
- Accept at start point T: on the edge, latch saved_h<=job_hash, load the schedule window with the 16 block words, and enter RUN.
  - cmp_counter=1 at T+1, incrementing by 1 per cycle to 63 at T+63.
  - Wraps to 0 at T+64 (FINISH).
  - The counter never holds at a non-zero value.
- W timing: cmp_W=W_{k-1} while cmp_counter=k (1..63); cmp_W=W_63 in FINISH.
- Message schedule:
  - W_t = block word t for t<16.
  - W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16} mod 2^32 for t>=16, with s0/s1 as in FIPS 180-4.
  - Implemented as a 16-word shift window; the window advances once per RUN cycle.
- FINISH cycle:
  - Push res = cmp_hash + saved_h, word-wise mod 2^32 (8 independent 32-bit adds, no carry between words).
  - If a job is accepted in the same cycle: cmp_inputhashstate=job_hash, saved_h/window reload on the same edge, and the counter goes to 1 next cycle. This gives back-to-back throughput of one job per 64 cycles.
  - Otherwise return to IDLE.
- Latency: job accepted at T -> res_valid=1 at T+65 when the FIFO was empty.
- Credit rule: job_ready = start_point && (fifo_count + finishing - pop) <= 1, where finishing=1 in the FINISH cycle and pop=res_valid&&res_ready. This guarantees a free FIFO slot at every completion; FIFO overflow is impossible by construction.
- FIFO:
  - Simultaneous push and pop is allowed at any occupancy, including full (count unchanged).
  - res_hash is stable while res_valid && !res_ready.
- busy=1 in RUN, including the FINISH cycle.
- rst mid-computation: the in-flight job and queued results are discarded; IDLE next cycle; no spurious res_valid.

Decomposition:
- Package sha_pkg: HashState (packed struct a..h, 8x32), SHA256_IV constant, functions s0/s1 (small sigmas), hs_add (word-wise feed-forward add).
- One sub-module: sha_msg_schedule (clk, rst, load, advance, block in, W out). It holds the 16-word window and computes the expansion.
- The result FIFO is written inline.

Test Plan:
- Single "abc" padded block, job_hash=SHA256_IV, res_ready=1 -> res_valid exactly 65 cycles after accept; res_hash=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Counter/W trace for the same job -> cmp_counter sequence 0,1..63,0. cmp_W=0x61626380 at counter=1; cmp_W=0x00000018 at counter=16.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" chained through res_hash -> final 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- res_ready=0, three jobs offered continuously:
  - job 1 accepted at T, job 2 accepted in job 1's FINISH (T+64), job_ready=0 thereafter.
  - Two results queued and held stable.
  - Raise res_ready -> job 3 accepted in the first start point where the credit rule allows.
- Back-to-back with res_ready=1 -> accepts at T and T+64; results at T+65 and T+129; no gap cycles on cmp_counter.
- rst asserted at counter=30 -> immediately IDLE, counter 0, res_valid=0, FIFO empty. A new "abc" job afterwards yields the correct digest.
